// File: rtl/manchester_tx_fifo_pkg.sv
`default_nettype none
//==============================================================================
// Module  : manchester_pkg
// Purpose : Shared types and helpers for the Manchester transmitter slice.
//           - state_t : frame sequencer states
//           - half_t  : which half of a Manchester bit is on the line
//           - preamble_word() : alternating 1/0 pattern, bit0 = 1
// Revision: 1.0 - initial release
//==============================================================================
package manchester_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        EOF  = 2'd3
    } state_t;

    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } half_t;

    // Returns the alternating preamble pattern in the low w bits (w <= 64);
    // callers cast the result down to their own word width.
    function automatic logic [63:0] preamble_word(input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            r[i] = (i < w) && ((i % 2) == 0);
        end
        return r;
    endfunction

endpackage : manchester_pkg
`default_nettype wire

// File: rtl/manchester_tx_fifo_if.sv
`default_nettype none
//==============================================================================
// Module  : manchester_tx_fifo_if
// Purpose : Host-side word interface of the Manchester transmitter.
//           data/wr   : word and enqueue strobe (host -> transmitter)
//           full/rdy  : FIFO full and its complement
//           count     : FIFO occupancy
//           ovf       : sticky overflow flag
//           master = host/producer, slave = transmitter.
// Revision: 1.0 - initial release
//==============================================================================
interface manchester_tx_fifo_if #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) ();

    logic [W-1:0]              data;
    logic                      wr;
    logic                      full;
    logic                      rdy;
    logic [$clog2(DEPTH):0]    count;
    logic                      ovf;

    modport master (
        output data,
        output wr,
        input  full,
        input  rdy,
        input  count,
        input  ovf
    );

    modport slave (
        input  data,
        input  wr,
        output full,
        output rdy,
        output count,
        output ovf
    );

endinterface : manchester_tx_fifo_if
`default_nettype wire

// File: rtl/manchester_tx_fifo_sync_fifo.sv
`default_nettype none
//==============================================================================
// Module  : sync_fifo
// Purpose : Single-clock first-word-fall-through word FIFO.
//           clk, rst (async, active low), push/din write side,
//           pop/dout read side (dout always shows the head word),
//           full, empty, count (occupancy, 0..DEPTH).
//           A push while full is ignored even if a pop happens in the
//           same cycle; a pop while empty is ignored.
// Revision: 1.0 - initial release
//==============================================================================
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [W-1:0]             din,
    output logic      [W-1:0]             dout,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_AW-1:0] r_wp;
    logic [c_AW-1:0] r_rp;
    logic [c_CW-1:0] r_cnt;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_cnt == c_CW'(DEPTH));
    assign empty     = (r_cnt == '0);
    assign count     = r_cnt;
    assign dout      = r_mem[r_rp];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage carries no reset; stale words are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wp] <= din;
        end
    end

    // Pointers are exactly c_AW bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_wp <= r_wp + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rp <= r_rp + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + c_CW'(1);
                2'b01:   r_cnt <= r_cnt - c_CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/manchester_tx_fifo.sv
`default_nettype none
//==============================================================================
// Module  : manchester_tx_fifo
// Purpose : Buffered Manchester transmitter. Words written over the host
//           interface are queued; each frame is PRE_WORDS preamble words,
//           every buffered word back to back, then EOF_HB idle-high
//           half-bits with the driver still enabled.
//           clk        system clock
//           rst        asynchronous, active-low reset
//           bus        host interface (data, wr, full, rdy, count, ovf)
//           txd        Manchester line output (LSB first, 1 = low->high)
//           txen       line driver enable, high for the whole frame
//           busy       sequencer not idle
// Revision: 1.0 - initial release
//==============================================================================
module manchester_tx_fifo
    import manchester_pkg::*;
#(
    parameter int CLKFREQ   = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int W         = 8,
    parameter int DEPTH     = 16,
    parameter int PRE_WORDS = 2,
    parameter int EOF_HB    = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    manchester_tx_fifo_if.slave     bus,
    output logic                    txd,
    output logic                    txen,
    output logic                    busy
);

    localparam int c_HB = CLKFREQ / (2 * BAUD);
    localparam int c_DW = $clog2(c_HB);
    localparam int c_BW = $clog2(W);
    localparam int c_PW = $clog2(PRE_WORDS + 1);
    localparam int c_EW = $clog2(EOF_HB + 1);

    localparam logic [c_DW-1:0] c_DIV_LAST  = c_DW'(c_HB - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(W - 1);
    localparam logic [c_PW-1:0] c_WORD_LAST = c_PW'(PRE_WORDS - 1);
    localparam logic [c_EW-1:0] c_EOF_LAST  = c_EW'(EOF_HB - 1);
    localparam logic [W-1:0]    c_PRE       = W'(preamble_word(W));

    // FIFO
    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic [W-1:0] w_dout;

    sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.wr),
        .pop   (w_pop),
        .din   (bus.data),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (bus.count)
    );

    assign bus.full = w_full;
    assign bus.rdy  = !w_full;

    // Sequencer state
    state_t          r_state, w_state_nxt;
    half_t           r_half,  w_half_nxt;
    logic [c_DW-1:0] r_div,   w_div_nxt;
    logic [c_BW-1:0] r_bit,   w_bit_nxt;
    logic [c_PW-1:0] r_word,  w_word_nxt;
    logic [c_EW-1:0] r_eof,   w_eof_nxt;
    logic [W-1:0]    r_shift, w_shift_nxt;
    logic            w_tick;
    logic            w_txd;
    logic            w_txen;

    logic            r_txd;
    logic            r_txen;
    logic            r_ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_half  <= FIRST;
            r_div   <= '0;
            r_bit   <= '0;
            r_word  <= '0;
            r_eof   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_half  <= w_half_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_word  <= w_word_nxt;
            r_eof   <= w_eof_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_half_nxt  = r_half;
        w_bit_nxt   = r_bit;
        w_word_nxt  = r_word;
        w_eof_nxt   = r_eof;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        w_txd       = 1'b1;
        w_txen      = (r_state != IDLE);

        // Divider is parked at 0 in IDLE so the first half-bit of a frame
        // lasts a full HB cycles.
        w_tick = (r_state != IDLE) && (r_div == c_DIV_LAST);
        if ((r_state == IDLE) || w_tick) begin
            w_div_nxt = '0;
        end else begin
            w_div_nxt = r_div + c_DW'(1);
        end

        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = PRE;
                    w_half_nxt  = FIRST;
                    w_bit_nxt   = '0;
                    w_word_nxt  = '0;
                    w_shift_nxt = c_PRE;
                end
            end

            PRE: begin
                w_txd = (r_half == FIRST) ? ~r_shift[0] : r_shift[0];
                if (w_tick) begin
                    if (r_half == FIRST) begin
                        w_half_nxt = SECOND;
                    end else begin
                        w_half_nxt = FIRST;
                        if (r_bit != c_BIT_LAST) begin
                            w_bit_nxt   = r_bit + c_BW'(1);
                            w_shift_nxt = r_shift >> 1;
                        end else begin
                            w_bit_nxt = '0;
                            if (r_word != c_WORD_LAST) begin
                                w_word_nxt  = r_word + c_PW'(1);
                                w_shift_nxt = c_PRE;
                            end else begin
                                // FIFO cannot be empty here: nothing else
                                // pops since the frame was started.
                                w_state_nxt = DATA;
                                w_pop       = 1'b1;
                                w_shift_nxt = w_dout;
                            end
                        end
                    end
                end
            end

            DATA: begin
                w_txd = (r_half == FIRST) ? ~r_shift[0] : r_shift[0];
                if (w_tick) begin
                    if (r_half == FIRST) begin
                        w_half_nxt = SECOND;
                    end else begin
                        w_half_nxt = FIRST;
                        if (r_bit != c_BIT_LAST) begin
                            w_bit_nxt   = r_bit + c_BW'(1);
                            w_shift_nxt = r_shift >> 1;
                        end else begin
                            w_bit_nxt = '0;
                            if (!w_empty) begin
                                // Chain the next word with no gap.
                                w_pop       = 1'b1;
                                w_shift_nxt = w_dout;
                            end else begin
                                w_state_nxt = EOF;
                                w_eof_nxt   = '0;
                            end
                        end
                    end
                end
            end

            EOF: begin
                if (w_tick) begin
                    if (r_eof == c_EOF_LAST) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_eof_nxt = r_eof + c_EW'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Line outputs are registered, so the line trails the sequencer by
    // one cycle while every half-bit keeps its full HB-cycle length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_txd  <= 1'b1;
            r_txen <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_txd  <= w_txd;
            r_txen <= w_txen;
            if (bus.wr && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign txd     = r_txd;
    assign txen    = r_txen;
    assign busy    = (r_state != IDLE);
    assign bus.ovf = r_ovf;

endmodule : manchester_tx_fifo
`default_nettype wire

// File: doc/manchester_tx_fifo.md
Name: manchester_tx_fifo

Overview:
- Parametrised Manchester-encoded serial transmitter, generalised in word width, buffer depth, preamble length and end-of-frame length.
- A word FIFO decouples the producer from the line, so back-to-back words go out as one continuous frame with no host timing constraint.
- Each frame is: preamble, then buffered words, then an idle-high end-of-frame marker.
- Sits between the host/command logic and the line driver; txen gates the driver.

Parameters:
- CLKFREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, bit rate in bits/s. Half-bit period HB = CLKFREQ/(2*BAUD) cycles; HB must be >= 2.
- W, 8, data word width.
- DEPTH, 16, FIFO depth in words; power of two, >= 2.
- PRE_WORDS, 2, number of W-bit preamble words sent before the first data word of a frame.
- EOF_HB, 4, length of the end-of-frame marker, in half-bit periods.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- data  in  W  word to enqueue.
- wr  in  1  enqueue strobe; data is captured when wr=1 and full=0.
- full  out  1  FIFO full.
- rdy  out  1  equals ~full.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- ovf  out  1  sticky; set when wr=1 while full=1; cleared only by reset.
- txd  out  1  Manchester line output.
- txen  out  1  line driver enable; high for the whole frame, including the EOF marker.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, FIFO empty, count=0, full=0, rdy=1, ovf=0, txd=1, txen=0, busy=0, half-bit divider=0.
- Half-bit tick: a counter runs 0..HB-1 and asserts tick when it reaches HB-1. It is held at 0 in IDLE, so the first half-bit of a frame lasts exactly HB cycles.
- Encoding: LSB first. For each bit b, the first half-bit drives ~b and the second half-bit drives b. So 1 -> low then high; 0 -> high then low.
- Preamble word: alternating pattern, bit0=1 (for W=8 this is 8'h55).
- States:
  - IDLE: txd=1, txen=0. If count!=0, go to PRE on the next cycle.
  - PRE: sends PRE_WORDS preamble words. After the last half-bit, pop the FIFO head into the shift register and go to DATA.
  - DATA: sends W bits = 2W half-bits. On the tick ending the final half-bit:
    - if count!=0, pop the next word and stay in DATA (no gap, no extra preamble);
    - otherwise go to EOF.
  - EOF: txd=1, txen=1 for EOF_HB half-bits, then IDLE.
- txd and txen are registered; each changes only on the cycle after a tick (or on the IDLE->PRE transition).
- Latency: a wr into an empty, idle block gives txen=1 and the first preamble half-bit on txd 2 cycles after the wr edge.
- FIFO rules:
  - A push while full is dropped and sets ovf, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- The FIFO accepts pushes during any state, including EOF. A word pushed during EOF does not extend the current frame; it starts a new frame (with preamble) after IDLE.
- Mid-frame reset: txd returns to 1 and txen to 0 immediately (asynchronous), and FIFO contents are discarded.

Decomposition:
- Package manchester_pkg holds:
  - state_t enum (IDLE, PRE, DATA, EOF);
  - half_t enum (FIRST, SECOND);
  - function preamble_word(W) returning the alternating pattern.
- One sub-module, sync_fifo:
  - parameters W, DEPTH;
  - ports clk, rst, push, pop, din, dout, full, empty, count;
  - first-word-fall-through output.
- The divider, frame FSM and shift register live in the top level.

Test Plan:
- Bench parameters: CLKFREQ=16, BAUD=1 (HB=8), W=8, DEPTH=4, PRE_WORDS=1, EOF_HB=4.
- Single word: push 8'hA3 -> txen rises 2 cycles later; txd shows 16 half-bits of 8'h55, then 16 half-bits for A3 LSB first (low/high, low/high, high/low, high/low, ...); then 32 cycles high with txen=1; then IDLE with txen=0, busy=0.
- Back-to-back: push 8'h00, 8'hFF, 8'h0F in consecutive cycles -> one frame: preamble then 48 data half-bits with no gap between words; count decrements at each word start; exactly one EOF.
- Overflow: push 6 words while txd is idle-bound -> count reaches 4, full=1, rdy=0. The 5th and 6th words are dropped, ovf=1 and stays 1 after the frame; exactly 4 words are transmitted.
- Refill in EOF: push a word during the 2nd EOF half-bit -> EOF completes its full 32 cycles, IDLE for 1 cycle, then a new frame with preamble.
- Async reset mid-DATA: drive rst=0 in the 5th bit -> txd=1 and txen=0 within the same cycle, count=0; after rst=1 the line stays idle with no residual frame.
